// File: rtl/axi4_lite_lb_bridge.sv
// AXI4-Lite slave to local-bus bridge with address window check
// and per-request ack timeout; read and write paths are independent.
module axi4_lite_lb_bridge #(
  parameter int                    ADDR_WIDTH     = 32,
  parameter int                    DATA_WIDTH     = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0,
  parameter logic [ADDR_WIDTH-1:0] ADDR_MASK      = '0,
  parameter int                    TIMEOUT_CYCLES = 256
) (
  input  logic                    S_AXI_ACLK,
  input  logic                    S_AXI_ARESET,
  input  logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic                    S_AXI_AWVALID,
  output logic                    S_AXI_AWREADY,
  input  logic [DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                    S_AXI_WVALID,
  output logic                    S_AXI_WREADY,
  output logic [1:0]              S_AXI_BRESP,
  output logic                    S_AXI_BVALID,
  input  logic                    S_AXI_BREADY,
  input  logic [ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic                    S_AXI_ARVALID,
  output logic                    S_AXI_ARREADY,
  output logic [DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]              S_AXI_RRESP,
  output logic                    S_AXI_RVALID,
  input  logic                    S_AXI_RREADY,
  output logic                    OP_LB_WREQ,
  output logic [ADDR_WIDTH-1:0]   OP_LB_WADR,
  output logic [DATA_WIDTH/8-1:0] OP_LB_WBEN,
  output logic [DATA_WIDTH-1:0]   OP_LB_WDAT,
  input  logic                    IP_LB_WACK,
  output logic                    OP_LB_RREQ,
  output logic [ADDR_WIDTH-1:0]   OP_LB_RADR,
  input  logic [DATA_WIDTH-1:0]   IP_LB_RDAT,
  input  logic                    IP_LB_RACK
);

  localparam int SW = DATA_WIDTH / 8;
  localparam int CW =
    (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int TO_LAST_I =
    (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [CW-1:0] TO_LAST = CW'(TO_LAST_I);
  localparam bit TO_EN = (TIMEOUT_CYCLES > 0);

  typedef enum logic [1:0] {W_IDLE, W_REQ, W_RESP} wst_t;
  typedef enum logic [1:0] {R_IDLE, R_REQ, R_RESP} rst_t;

  function automatic logic hit(input logic [ADDR_WIDTH-1:0] a);
    return (a & ADDR_MASK) == BASE_ADDR;
  endfunction

  wst_t                  wst_q, wst_d;
  logic                  awready_q, awready_d;
  logic                  wready_q, wready_d;
  logic [ADDR_WIDTH-1:0] wadr_q, wadr_d;
  logic [DATA_WIDTH-1:0] wdat_q, wdat_d;
  logic [SW-1:0]         wben_q, wben_d;
  logic                  wreq_q, wreq_d;
  logic                  bvalid_q, bvalid_d;
  logic [1:0]            bresp_q, bresp_d;
  logic [CW-1:0]         wcnt_q, wcnt_d;

  rst_t                  rst_q, rst_d;
  logic                  arready_q, arready_d;
  logic [ADDR_WIDTH-1:0] radr_q, radr_d;
  logic                  rreq_q, rreq_d;
  logic                  rvalid_q, rvalid_d;
  logic [1:0]            rresp_q, rresp_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [CW-1:0]         rcnt_q, rcnt_d;

  // A low READY in W_IDLE doubles as the "already captured" flag.
  always_comb begin
    wst_d     = wst_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    wadr_d    = wadr_q;
    wdat_d    = wdat_q;
    wben_d    = wben_q;
    wreq_d    = wreq_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    wcnt_d    = wcnt_q;
    unique case (wst_q)
      W_IDLE: begin
        if (awready_q && S_AXI_AWVALID) begin
          wadr_d    = S_AXI_AWADDR;
          awready_d = 1'b0;
        end
        if (wready_q && S_AXI_WVALID) begin
          wdat_d   = S_AXI_WDATA;
          wben_d   = S_AXI_WSTRB;
          wready_d = 1'b0;
        end
        if (!awready_d && !wready_d) begin
          if (hit(wadr_d)) begin
            wst_d  = W_REQ;
            wreq_d = 1'b1;
            wcnt_d = '0;
          end else begin
            wst_d    = W_RESP;
            bvalid_d = 1'b1;
            bresp_d  = 2'b11;
          end
        end
      end
      W_REQ: begin
        if (IP_LB_WACK) begin
          wst_d    = W_RESP;
          wreq_d   = 1'b0;
          bvalid_d = 1'b1;
          bresp_d  = 2'b00;
        end else if (TO_EN && wcnt_q == TO_LAST) begin
          wst_d    = W_RESP;
          wreq_d   = 1'b0;
          bvalid_d = 1'b1;
          bresp_d  = 2'b10;
        end else begin
          wcnt_d = wcnt_q + CW'(1);
        end
      end
      W_RESP: begin
        if (S_AXI_BREADY) begin
          wst_d     = W_IDLE;
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
          wready_d  = 1'b1;
        end
      end
      default: wst_d = W_IDLE;
    endcase
  end

  always_comb begin
    rst_d     = rst_q;
    arready_d = arready_q;
    radr_d    = radr_q;
    rreq_d    = rreq_q;
    rvalid_d  = rvalid_q;
    rresp_d   = rresp_q;
    rdata_d   = rdata_q;
    rcnt_d    = rcnt_q;
    unique case (rst_q)
      R_IDLE: begin
        if (arready_q && S_AXI_ARVALID) begin
          radr_d    = S_AXI_ARADDR;
          arready_d = 1'b0;
          if (hit(S_AXI_ARADDR)) begin
            rst_d  = R_REQ;
            rreq_d = 1'b1;
            rcnt_d = '0;
          end else begin
            rst_d    = R_RESP;
            rvalid_d = 1'b1;
            rresp_d  = 2'b11;
            rdata_d  = '0;
          end
        end
      end
      R_REQ: begin
        if (IP_LB_RACK) begin
          rst_d    = R_RESP;
          rreq_d   = 1'b0;
          rvalid_d = 1'b1;
          rresp_d  = 2'b00;
          rdata_d  = IP_LB_RDAT;
        end else if (TO_EN && rcnt_q == TO_LAST) begin
          rst_d    = R_RESP;
          rreq_d   = 1'b0;
          rvalid_d = 1'b1;
          rresp_d  = 2'b10;
          rdata_d  = '0;
        end else begin
          rcnt_d = rcnt_q + CW'(1);
        end
      end
      R_RESP: begin
        if (S_AXI_RREADY) begin
          rst_d     = R_IDLE;
          rvalid_d  = 1'b0;
          arready_d = 1'b1;
        end
      end
      default: rst_d = R_IDLE;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      wst_q     <= W_IDLE;
      awready_q <= 1'b1;
      wready_q  <= 1'b1;
      wadr_q    <= '0;
      wdat_q    <= '0;
      wben_q    <= '0;
      wreq_q    <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      wcnt_q    <= '0;
      rst_q     <= R_IDLE;
      arready_q <= 1'b1;
      radr_q    <= '0;
      rreq_q    <= 1'b0;
      rvalid_q  <= 1'b0;
      rresp_q   <= 2'b00;
      rdata_q   <= '0;
      rcnt_q    <= '0;
    end else begin
      wst_q     <= wst_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      wadr_q    <= wadr_d;
      wdat_q    <= wdat_d;
      wben_q    <= wben_d;
      wreq_q    <= wreq_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      wcnt_q    <= wcnt_d;
      rst_q     <= rst_d;
      arready_q <= arready_d;
      radr_q    <= radr_d;
      rreq_q    <= rreq_d;
      rvalid_q  <= rvalid_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
      rcnt_q    <= rcnt_d;
    end
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RRESP   = rresp_q;
  assign S_AXI_RDATA   = rdata_q;
  assign OP_LB_WREQ    = wreq_q;
  assign OP_LB_WADR    = wadr_q;
  assign OP_LB_WDAT    = wdat_q;
  assign OP_LB_WBEN    = wben_q;
  assign OP_LB_RREQ    = rreq_q;
  assign OP_LB_RADR    = radr_q;

endmodule

// File: tb/tb_axi4_lite_lb_bridge.sv
// Directed bench for axi4_lite_lb_bridge: vector table plus
// hand sequences for ordering, backpressure, timeout and reset.
module tb_axi4_lite_lb_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] awaddr = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b1;
  logic [31:0] araddr = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b1;
  logic        lb_wreq;
  logic [31:0] lb_wadr;
  logic [3:0]  lb_wben;
  logic [31:0] lb_wdat;
  logic        lb_wack = 1'b0;
  logic        lb_rreq;
  logic [31:0] lb_radr;
  logic [31:0] lb_rdat = '0;
  logic        auto_rack = 1'b0;
  logic        man_rack = 1'b0;
  logic        lb_rack;

  assign lb_rack = auto_rack | man_rack;

  always #5 clk = ~clk;

  axi4_lite_lb_bridge #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .BASE_ADDR(32'h4000_0000),
    .ADDR_MASK(32'hF000_0000),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .S_AXI_ACLK(clk),
    .S_AXI_ARESET(rst),
    .S_AXI_AWADDR(awaddr),
    .S_AXI_AWVALID(awvalid),
    .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata),
    .S_AXI_WSTRB(wstrb),
    .S_AXI_WVALID(wvalid),
    .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp),
    .S_AXI_BVALID(bvalid),
    .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr),
    .S_AXI_ARVALID(arvalid),
    .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata),
    .S_AXI_RRESP(rresp),
    .S_AXI_RVALID(rvalid),
    .S_AXI_RREADY(rready),
    .OP_LB_WREQ(lb_wreq),
    .OP_LB_WADR(lb_wadr),
    .OP_LB_WBEN(lb_wben),
    .OP_LB_WDAT(lb_wdat),
    .IP_LB_WACK(lb_wack),
    .OP_LB_RREQ(lb_rreq),
    .OP_LB_RADR(lb_radr),
    .IP_LB_RDAT(lb_rdat),
    .IP_LB_RACK(lb_rack)
  );

  // Local-bus responder: ack after dly+1 REQ cycles, -1 = never.
  int          wack_dly = 0;
  int          rack_dly = 0;
  logic [31:0] rack_val = '0;
  int          wcyc = 0;
  int          rcyc = 0;
  int          wreq_tot = 0;
  int          rreq_tot = 0;
  logic [31:0] seen_wadr = '0;
  logic [31:0] seen_wdat = '0;
  logic [3:0]  seen_wben = '0;

  initial forever begin
    @(negedge clk);
    if (lb_wreq) begin
      if (wcyc == 0) begin
        seen_wadr = lb_wadr;
        seen_wdat = lb_wdat;
        seen_wben = lb_wben;
      end
      wcyc++;
      wreq_tot++;
      lb_wack = (wack_dly >= 0) && (wcyc == wack_dly + 1);
    end else begin
      wcyc = 0;
      lb_wack = 1'b0;
    end
    if (lb_rreq) begin
      rcyc++;
      rreq_tot++;
      auto_rack = (rack_dly >= 0) && (rcyc == rack_dly + 1);
      lb_rdat = auto_rack ? rack_val : 32'h0BAD_0BAD;
    end else begin
      rcyc = 0;
      auto_rack = 1'b0;
    end
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, output logic [1:0] resp,
                          output bit to);
    int n;
    awaddr = a; wdata = d; wstrb = s;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    step();
    awvalid = 1'b0; wvalid = 1'b0;
    n = 0;
    while (!bvalid && n < 40) begin
      step();
      n++;
    end
    to = !bvalid;
    resp = bresp;
    step();
  endtask

  task automatic do_read(input logic [31:0] a, output logic [1:0] resp,
                         output logic [31:0] d, output bit to);
    int n;
    araddr = a; arvalid = 1'b1; rready = 1'b1;
    step();
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 40) begin
      step();
      n++;
    end
    to = !rvalid;
    resp = rresp;
    d = rdata;
    step();
  endtask

  typedef struct {
    bit          rd;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          dly;
    logic [1:0]  eresp;
    logic [31:0] edata;
    int          ereq;
  } vec_t;

  vec_t vecs[9];

  initial begin
    vec_t        v;
    logic [1:0]  resp;
    logic [31:0] d;
    bit          to;
    int          w0, r0, n;

    vecs[0] = '{0, 32'h4000_0010, 32'hA5A5_0001, 4'hF, 0, 2'b00, 32'hA5A5_0001, 1};
    vecs[1] = '{0, 32'h4000_0020, 32'hDEAD_BEEF, 4'h0, 3, 2'b00, 32'hDEAD_BEEF, 4};
    vecs[2] = '{0, 32'h5000_0004, 32'h1111_2222, 4'h3, 0, 2'b11, 32'h0, 0};
    vecs[3] = '{0, 32'h4000_0030, 32'h3333_4444, 4'hC, -1, 2'b10, 32'h3333_4444, 8};
    vecs[4] = '{0, 32'h4FFF_FFFC, 32'h5555_6666, 4'h9, 7, 2'b00, 32'h5555_6666, 8};
    vecs[5] = '{1, 32'h4000_0004, 32'h1234_5678, 4'h0, 0, 2'b00, 32'h1234_5678, 1};
    vecs[6] = '{1, 32'h5000_0004, 32'hFFFF_FFFF, 4'h0, 0, 2'b11, 32'h0, 0};
    vecs[7] = '{1, 32'h4000_0008, 32'hCAFE_F00D, 4'h0, -1, 2'b10, 32'h0, 8};
    vecs[8] = '{1, 32'h4000_000C, 32'h8765_4321, 4'h0, 7, 2'b00, 32'h8765_4321, 8};

    #23;
    chk("rst_awready", awready, 1);
    chk("rst_wready", wready, 1);
    chk("rst_arready", arready, 1);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_reqs", {lb_wreq, lb_rreq}, 0);
    chk("rst_rdata", rdata, 0);
    @(negedge clk);
    rst = 1'b0;
    step();

    for (int i = 0; i < 9; i++) begin
      v = vecs[i];
      if (v.rd) begin
        rack_dly = v.dly;
        rack_val = v.data;
        r0 = rreq_tot;
        do_read(v.addr, resp, d, to);
        chk("rd_done", to, 0);
        chk("rresp", resp, v.eresp);
        chk("rdata", d, v.edata);
        chk("rreq_cycles", rreq_tot - r0, v.ereq);
      end else begin
        wack_dly = v.dly;
        w0 = wreq_tot;
        do_write(v.addr, v.data, v.strb, resp, to);
        chk("wr_done", to, 0);
        chk("bresp", resp, v.eresp);
        chk("wreq_cycles", wreq_tot - w0, v.ereq);
        if (v.ereq > 0) begin
          chk("wadr", seen_wadr, v.addr);
          chk("wdat", seen_wdat, v.edata);
          chk("wben", seen_wben, v.strb);
        end
      end
      chk("idle_ready", {awready, wready, arready, bvalid, rvalid},
          5'b11100);
      step();
    end

    // AW first, W three cycles later; zero-wait ack
    wack_dly = 0;
    bready = 1'b0;
    w0 = wreq_tot;
    awaddr = 32'h4000_0010; awvalid = 1'b1;
    step();
    awvalid = 1'b0;
    chk("aw_first_awready", {awready, wready, lb_wreq}, 3'b010);
    step();
    step();
    wdata = 32'hA5A5_0001; wstrb = 4'hF; wvalid = 1'b1;
    step();
    wvalid = 1'b0;
    chk("aw_first_wreq", {lb_wreq, bvalid}, 2'b10);
    step();
    chk("aw_first_bvalid", {lb_wreq, bvalid, bresp}, 4'b0100);
    bready = 1'b1;
    step();
    chk("aw_first_one_req", wreq_tot - w0, 1);
    chk("aw_first_wdat", seen_wdat, 32'hA5A5_0001);

    // W before AW, then BREADY held low for 4 cycles
    wack_dly = 1;
    bready = 1'b0;
    wdata = 32'h0F0F_0F0F; wstrb = 4'h5; wvalid = 1'b1;
    step();
    wvalid = 1'b0;
    chk("w_first_ready", {awready, wready, lb_wreq}, 3'b100);
    awaddr = 32'h4000_0044; awvalid = 1'b1;
    step();
    awvalid = 1'b0;
    chk("w_first_wreq", lb_wreq, 1);
    n = 0;
    while (!bvalid && n < 20) begin
      step();
      n++;
    end
    chk("w_first_bvalid", bvalid, 1);
    w0 = wreq_tot;
    awvalid = 1'b1; wvalid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("bhold", {bvalid, bresp, awready, wready, lb_wreq}, 6'b100000);
      step();
    end
    awvalid = 1'b0; wvalid = 1'b0;
    chk("bhold_no_req", wreq_tot - w0, 0);
    bready = 1'b1;
    step();
    chk("bhold_release", {bvalid, awready, wready}, 3'b011);
    chk("w_first_wadr", seen_wadr, 32'h4000_0044);

    // Read timeout then a stray late ack
    rack_dly = -1;
    r0 = rreq_tot;
    do_read(32'h4000_0100, resp, d, to);
    chk("to_rresp", {resp, d}, {2'b10, 32'h0});
    chk("to_rreq_cycles", rreq_tot - r0, 8);
    man_rack = 1'b1;
    step();
    man_rack = 1'b0;
    step();
    chk("late_ack_ignored", {rvalid, lb_rreq, arready}, 3'b001);

    // Concurrent write and read
    wack_dly = 1;
    rack_dly = 4;
    rack_val = 32'h1234_5678;
    bready = 1'b0; rready = 1'b0;
    awaddr = 32'h4000_0200; wdata = 32'h1234_5678; wstrb = 4'hF;
    araddr = 32'h4000_0204;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    step();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    chk("conc_both_req", {lb_wreq, lb_rreq}, 2'b11);
    n = 0;
    while (!(bvalid && rvalid) && n < 30) begin
      step();
      n++;
    end
    chk("conc_done", {bvalid, rvalid}, 2'b11);
    chk("conc_resp", {bresp, rresp}, 4'b0000);
    chk("conc_rdata", rdata, 32'h1234_5678);
    chk("conc_wdat", seen_wdat, 32'h1234_5678);
    bready = 1'b1; rready = 1'b1;
    step();
    chk("conc_release", {bvalid, rvalid}, 2'b00);

    // Asynchronous reset during R_REQ
    rack_dly = -1;
    araddr = 32'h4000_0300; arvalid = 1'b1;
    step();
    arvalid = 1'b0;
    chk("rst_mid_rreq", lb_rreq, 1);
    step();
    rst = 1'b1;
    #1;
    chk("rst_mid_drop", {lb_rreq, rvalid, arready}, 3'b001);
    #1;
    rst = 1'b0;
    step();
    chk("rst_mid_idle", {lb_rreq, rvalid, arready}, 3'b001);
    rack_dly = 0;
    rack_val = 32'h7777_8888;
    do_read(32'h4000_0304, resp, d, to);
    chk("post_rst_read", {to, resp, d}, {1'b0, 2'b00, 32'h7777_8888});

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
